// File: rtl/coherent_dcache_ctrl.sv
// MSI-coherent direct-mapped data cache controller: 2-word blocks, core-side hits in
// zero cycles, bus-side fetch/upgrade/writeback, and snoop service with dirty writeback.
module coherent_dcache_ctrl #(
  parameter int SETS  = 8,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic [3:0]  dbg_state
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - 3 - IW;

  // Bus handshake: a bus state holds all its outputs stable until dwait is sampled low
  // at a rising edge; that edge transfers exactly one word and advances the state.
  typedef enum logic [3:0] {
    IDLE, UPGRADE, WB1, WB2, FETCH1, FETCH2, SNOOP, SWB1, SWB2
  } state_t;

  state_t            state_q;
  logic [SETS-1:0]   valid_q, dirty_q;
  logic [TW-1:0]     tag_q   [SETS];
  logic [31:0]       word0_q [SETS];
  logic [31:0]       word1_q [SETS];
  logic [TW+IW-1:0]  snp_blk_q;
  logic              snp_inv_q;

  logic [IW-1:0] req_idx, snp_idx, slat_idx;
  logic [TW-1:0] req_tag, snp_tag;
  logic          req_off, req_any, req_hit, snp_hit, snp_m;
  logic [31:0]   req_word;
  logic          store_we, fill0_we, fill1_we;
  logic          unused_bits;

  assign req_idx  = dmemaddr[3 +: IW];
  assign req_tag  = dmemaddr[31 -: TW];
  assign req_off  = dmemaddr[2];
  assign req_any  = dmemREN | dmemWEN;
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign req_word = req_off ? word1_q[req_idx] : word0_q[req_idx];
  assign snp_idx  = ccsnoopaddr[3 +: IW];
  assign snp_tag  = ccsnoopaddr[31 -: TW];
  assign snp_hit  = valid_q[snp_idx] && (tag_q[snp_idx] == snp_tag);
  assign snp_m    = snp_hit && dirty_q[snp_idx];
  assign slat_idx = snp_blk_q[IW-1:0];
  assign store_we = dhit && dmemWEN;
  assign fill0_we = (state_q == FETCH1) && !dwait;
  assign fill1_we = (state_q == FETCH2) && !dwait;
  assign dbg_state   = state_q;
  assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[2:0], CPUID[0]};

  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending snoop stalls the core even when its request would hit.
        if (!ccwait && req_any && req_hit && (!dmemWEN || dirty_q[req_idx])) begin
          dhit     = 1'b1;
          dmemload = req_word;
        end
      end
      UPGRADE: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 3'b000};
        dstore = word0_q[req_idx];
      end
      WB2: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 3'b100};
        dstore = word1_q[req_idx];
      end
      FETCH1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = {dmemaddr[31:3], 3'b000};
      end
      FETCH2: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = {dmemaddr[31:3], 3'b100};
      end
      SNOOP: begin
        cctrans = snp_m;
        ccwrite = snp_m;
      end
      SWB1: begin
        dWEN   = 1'b1;
        daddr  = {snp_blk_q, 3'b000};
        dstore = word0_q[slat_idx];
      end
      SWB2: begin
        dWEN   = 1'b1;
        daddr  = {snp_blk_q, 3'b100};
        dstore = word1_q[slat_idx];
      end
      default: ;
    endcase
  end

  // Tag and data arrays carry no reset; valid bits gate every use of them.
  always_ff @(posedge CLK) begin
    if (store_we) begin
      if (req_off) word1_q[req_idx] <= dmemstore;
      else         word0_q[req_idx] <= dmemstore;
    end
    if (fill0_we) word0_q[req_idx] <= dload;
    if (fill1_we) begin
      word1_q[req_idx] <= dload;
      tag_q[req_idx]   <= req_tag;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      snp_blk_q <= '0;
      snp_inv_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ccwait) state_q <= SNOOP;
          else if (req_any) begin
            if (req_hit) begin
              if (dmemWEN && !dirty_q[req_idx]) state_q <= UPGRADE;
            end else if (valid_q[req_idx] && dirty_q[req_idx]) state_q <= WB1;
            else state_q <= FETCH1;
          end
        end
        UPGRADE: if (!dwait) begin
          dirty_q[req_idx] <= 1'b1;
          state_q          <= IDLE;
        end
        WB1:    if (!dwait) state_q <= WB2;
        WB2:    if (!dwait) state_q <= FETCH1;
        FETCH1: if (!dwait) state_q <= FETCH2;
        FETCH2: if (!dwait) begin
          valid_q[req_idx] <= 1'b1;
          dirty_q[req_idx] <= dmemWEN;
          state_q          <= IDLE;
        end
        SNOOP: begin
          // The snooped block and invalidate flag are held for the writeback states.
          snp_blk_q <= ccsnoopaddr[31:3];
          snp_inv_q <= ccinv;
          if (snp_m) state_q <= SWB1;
          else begin
            if (snp_hit && ccinv) valid_q[snp_idx] <= 1'b0;
            state_q <= IDLE;
          end
        end
        SWB1: if (!dwait) state_q <= SWB2;
        SWB2: if (!dwait) begin
          dirty_q[slat_idx] <= 1'b0;
          if (snp_inv_q) valid_q[slat_idx] <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_dcache_ctrl.sv
// Bench for coherent_dcache_ctrl: directed test-plan steps then random loads, stores and
// snoops, checked against a word-level memory model and a per-set MSI line model.
module tb_coherent_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        cctrans, ccwrite;
  logic        ccwait, ccinv;
  logic [31:0] ccsnoopaddr;
  logic [3:0]  dbg_state;

  coherent_dcache_ctrl #(.SETS(8), .CPUID(0)) dut (
    .CLK(CLK), .RST(RST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state: architectural memory (ref_mem), backing memory (bus_mem), line model
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] bus_mem [64];
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [25:0] m_tag   [8];
  logic [32:0] exp_q[$];
  int          busy_cyc;
  int          upg_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, dhit, dREN, dWEN, cctrans, ccwrite}, 32'd0);
    chk({tag, "_daddr"}, daddr, 32'd0);
    chk({tag, "_dstore"}, dstore, 32'd0);
    chk({tag, "_dmemload"}, dmemload, 32'd0);
  endtask

  // Memory-side driver, called at a falling edge: decides dwait and serves accepted words.
  task automatic bus_service(input bit wr_req);
    logic [32:0] e;
    if (dREN || dWEN || cctrans) begin
      busy_cyc++;
      dwait = ($urandom_range(0, 3) == 0);
      if (!dwait) begin
        if (!dREN && !dWEN) begin
          upg_seen++;
          chk("upgrade_ccwrite", 32'(ccwrite), 32'd1);
        end else begin
          chk("bus_op_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bus_dir", 32'(dWEN), 32'(e[32]));
            chk("bus_addr", daddr, e[31:0]);
          end
          if (dWEN) begin
            chk("wb_data", dstore, ref_mem[daddr[7:2]]);
            bus_mem[daddr[7:2]] = dstore;
          end else begin
            chk("fetch_cc", {30'd0, cctrans, ccwrite}, {30'd0, 1'b1, wr_req});
            dload = bus_mem[daddr[7:2]];
          end
        end
      end
    end else begin
      dwait = 1'b1;
    end
  endtask

  // Core-side driver; entered and left just after a rising edge.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int          idx, cyc;
    bit          hit, expect_bus, exp_upg, done;
    logic [25:0] tg;
    idx = int'(a[5:3]);
    tg  = a[31:6];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_q.delete();
    busy_cyc = 0; upg_seen = 0; expect_bus = 0; exp_upg = 0; done = 0; cyc = 0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_q.push_back({1'b1, m_tag[idx], idx[2:0], 3'b000});
        exp_q.push_back({1'b1, m_tag[idx], idx[2:0], 3'b100});
      end
      exp_q.push_back({1'b0, a[31:3], 3'b000});
      exp_q.push_back({1'b0, a[31:3], 3'b100});
      expect_bus = 1;
    end else if (wr && !m_dirty[idx]) begin
      exp_upg = 1; expect_bus = 1;
    end
    dmemWEN = wr;
    dmemREN = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    dmemaddr = a; dmemstore = d;
    while (!done && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      if (dhit) begin
        done = 1; dwait = 1'b1;
        if (!wr) chk("load_data", dmemload, ref_mem[a[7:2]]);
      end else begin
        bus_service(wr);
      end
      @(posedge CLK); #1;
    end
    chk("dhit_seen", 32'(done), 32'd1);
    chk("bus_ops_left", 32'(exp_q.size()), 32'd0);
    chk("upgrades", 32'(upg_seen), 32'(exp_upg));
    chk("latency", 32'(cyc), expect_bus ? 32'(busy_cyc + 2) : 32'd1);
    dmemREN = 1'b0; dmemWEN = 1'b0;
    if (wr) ref_mem[a[7:2]] = d;
    m_dirty[idx] = hit ? (m_dirty[idx] | wr) : wr;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
  endtask

  // Snoop driver; entered and left just after a rising edge with no core request.
  task automatic snoop(input logic [31:0] a, input bit inv);
    int idx, cyc;
    bit hit, m;
    idx = int'(a[5:3]);
    hit = m_valid[idx] && (m_tag[idx] == a[31:6]);
    m   = hit && m_dirty[idx];
    exp_q.delete();
    busy_cyc = 0; cyc = 0; dwait = 1'b1;
    if (m) begin
      exp_q.push_back({1'b1, a[31:3], 3'b000});
      exp_q.push_back({1'b1, a[31:3], 3'b100});
    end
    ccwait = 1'b1; ccsnoopaddr = a; ccinv = inv;
    @(posedge CLK); #1;
    ccwait = 1'b0;
    @(negedge CLK);
    chk("snoop_cctrans", 32'(cctrans), 32'(m));
    chk("snoop_ccwrite", 32'(ccwrite), 32'(m));
    chk("snoop_no_bus", {30'd0, dREN, dWEN}, 32'd0);
    @(posedge CLK); #1;
    ccsnoopaddr = $urandom; ccinv = ~inv;
    while (exp_q.size() > 0 && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      bus_service(1'b0);
      @(posedge CLK); #1;
    end
    chk("snoop_wb_left", 32'(exp_q.size()), 32'd0);
    dwait = 1'b1;
    @(negedge CLK);
    chk("snoop_back_idle", {28'd0, dREN, dWEN, cctrans, ccwrite}, 32'd0);
    @(posedge CLK); #1;
    ccinv = 1'b0;
    if (m) begin
      m_dirty[idx] = 1'b0;
      if (inv) m_valid[idx] = 1'b0;
    end else if (hit && inv) begin
      m_valid[idx] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          cyc;
    bit          found;
    RST = 1'b1; dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0;
    dload = 0; dwait = 1'b1; ccwait = 0; ccinv = 0; ccsnoopaddr = 0;
    for (int i = 0; i < 64; i++) bus_mem[i] = $urandom;
    bus_mem[16] = 32'h0000_AAAA;
    bus_mem[17] = 32'h0000_BBBB;
    for (int i = 0; i < 64; i++) ref_mem[i] = bus_mem[i];
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
    #12;
    check_all_zero("reset");
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    check_all_zero("after_reset");

    // Directed steps from the test plan
    access(1'b0, 32'h40, 32'h0);
    access(1'b1, 32'h44, 32'h1234);
    access(1'b0, 32'h44, 32'h0);
    access(1'b0, 32'h80, 32'h0);
    access(1'b1, 32'h80, 32'hCAFE);
    snoop(32'h80, 1'b0);
    access(1'b0, 32'h80, 32'h0);
    snoop(32'h84, 1'b1);
    access(1'b0, 32'h84, 32'h0);

    // Snoop and core read arrive together: snoop is served first
    ccwait = 1'b1; ccsnoopaddr = 32'hC8; ccinv = 1'b1;
    dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = 32'h84;
    @(negedge CLK);
    chk("prio_dhit_idle", 32'(dhit), 32'd0);
    @(posedge CLK); #1;
    ccwait = 1'b0; ccinv = 1'b0;
    @(negedge CLK);
    chk("prio_dhit_snoop", 32'(dhit), 32'd0);
    chk("prio_snoop_cc", {30'd0, cctrans, ccwrite}, 32'd0);
    @(posedge CLK); #1;
    access(1'b0, 32'h84, 32'h0);

    // Random mix over a 64-word window (4 tags x 8 sets x 2 words)
    for (int n = 0; n < 400; n++) begin
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 9) < 2) snoop(a, 1'($urandom_range(0, 1)));
      else access(1'($urandom_range(0, 1)), a, $urandom);
    end

    // Reset in the middle of FETCH2
    a = (m_valid[0] && m_tag[0] == 26'd0) ? 32'h40 : 32'h00;
    dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = a; dwait = 1'b0;
    found = 0; cyc = 0;
    while (!found && cyc < 50) begin
      @(negedge CLK);
      cyc++;
      if (dWEN) bus_mem[daddr[7:2]] = dstore;
      if (dREN) dload = bus_mem[daddr[7:2]];
      if (dREN && daddr[2]) found = 1;
      else begin @(posedge CLK); #1; end
    end
    chk("reached_fetch2", 32'(found), 32'd1);
    dwait = 1'b1;
    #1 RST = 1'b1;
    #1 check_all_zero("reset_mid_fetch2");
    dmemREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = bus_mem[i];
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    access(1'b0, a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coherent_dcache_ctrl.md
# coherent_dcache_ctrl

Per-CPU MSI-coherent data cache controller that sits between a core's data port and the shared coherence/memory controller. It serves loads and stores from a direct-mapped store of 8 two-word blocks, and issues coherent fetches, upgrades and writebacks on the bus side. It also answers snoops arriving from the controller, so it is the cache-side end of the cctrans/ccwrite/ccwait/ccinv/ccsnoopaddr protocol.

## Interface
Parameters:
- SETS, 8: number of direct-mapped frames, 2 words each. Index is addr[5:3], block offset is addr[2], tag is addr[31:6].
- CPUID, 0: identifier, informational only (no logic depends on it).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- dmemREN, dmemWEN  in  1 each  core read/write request, held until dhit.
- dmemaddr  in  32  word-aligned byte address.
- dmemstore  in  32  store data.
- dhit  out  1  request completes this cycle.
- dmemload  out  32  load data, valid with dhit.
- dREN, dWEN  out  1 each  bus read/write request.
- daddr  out  32  bus address.
- dstore  out  32  bus write data.
- dload  in  32  bus read data.
- dwait  in  1  bus word accepted/returned when low at a rising edge.
- cctrans  out  1  coherence transaction / snoop-hit-dirty flag.
- ccwrite  out  1  exclusive intent (GetX/upgrade) / snoop-supplies-data flag.
- ccwait  in  1  controller is snooping this cache.
- ccinv  in  1  invalidate snooped block.
- ccsnoopaddr  in  32  address being snooped.

## Operation
- Each frame holds: valid, dirty (M), tag, and 2 words. Line states are I (invalid), S (valid & !dirty), M (valid & dirty).
- FSM states: IDLE, UPGRADE, WB1, WB2, FETCH1, FETCH2, SNOOP, SWB1, SWB2.
- IDLE with ccwait=1: go to SNOOP. Core requests are stalled (dhit=0) and snoops take priority over core requests.
- IDLE, read hit (S or M): dhit=1 combinationally, dmemload = addressed word.
- IDLE, write hit on M: dhit=1 and the word is written at the edge.
- IDLE, write hit on S: go to UPGRADE.
- IDLE, miss: go to WB1 if the victim frame is M, else to FETCH1.
- UPGRADE: cctrans=1, ccwrite=1, dREN=dWEN=0. On dwait=0 the line becomes M and the FSM returns to IDLE, where the write then hits.
- WB1/WB2: dWEN=1, cctrans=0, daddr={victim tag, index, offset, 2'b00} with offset 0 then 1, dstore = victim word. Each state advances on dwait=0. WB2 then goes to FETCH1.
- FETCH1/FETCH2: dREN=1, cctrans=1, ccwrite=dmemWEN, daddr = request block with offset 0 then 1. dload is captured on dwait=0. After FETCH2 the tag and valid bit are set, dirty=dmemWEN, and the FSM returns to IDLE, where the request hits on the next cycle.
- SNOOP (one cycle): look up ccsnoopaddr.
  - Hit on M: cctrans=1, ccwrite=1, go to SWB1.
  - Otherwise: cctrans=0, ccwrite=0. If the block hits and ccinv=1, clear valid. Return to IDLE.
- SWB1/SWB2: dWEN=1, daddr = snooped block offset 0/1, dstore = cached word, advancing on dwait=0. After SWB2, dirty is cleared, and valid is also cleared if ccinv was 1 during SNOOP (latched).
- A miss is never snooped mid-transaction: ccwait is sampled only in IDLE. The controller serialises bus ownership.

## Timing
- Reset (RST=1, async): all valid/dirty bits cleared, FSM to IDLE. dhit, dREN, dWEN, cctrans, ccwrite = 0; daddr, dstore, dmemload = 0. Data arrays need no reset.
- Hit latency: 0 cycles (dhit in the request cycle).
- Clean miss latency: 2 bus words + 1 IDLE cycle.
- Dirty miss latency: 4 bus words + 1 IDLE cycle.
- Each bus state holds its outputs stable while dwait=1, for an unbounded wait.
- Bus outputs are 0 in IDLE. dhit is 0 in every state other than IDLE.
- RST asserted mid-transaction aborts immediately. There is no partial writeback recovery.
- When dmemREN and dmemWEN are both high, treat the request as a write.

## Test plan
- Reset, then read 0x40: FETCH1/2 with cctrans=1, ccwrite=0, dload 0xAAAA/0xBBBB. The next cycle gives dhit=1 and dmemload=0xAAAA, and the line is in S.
- Write 0x44 ← 0x1234 on that S line: UPGRADE (cctrans=1, ccwrite=1). After dwait=0 the write hits, the line is in M, and a read of 0x44 returns 0x1234.
- Conflict read 0x80 (same index) on the M line: WB1/WB2 write 0xAAAA to 0x40 and 0x1234 to 0x44, then FETCH 0x80/0x84.
- Snoop 0x80 with ccinv=0 on an M line: SNOOP drives cctrans=1, ccwrite=1. SWB1/2 write both words, and the line ends in S.
- Snoop with ccinv=1 on an S line: cctrans=0, and a subsequent read of that block misses.
- ccwait and dmemREN rise together: the snoop completes first, dhit stays 0 until the FSM is back in IDLE, and RST mid-FETCH2 returns all outputs to 0 in the same cycle.
